tdisto_accum: RTL
=================

# tdisto_accum

Pipelined, parametrised spectral-distortion engine for the mode-decision path. It accepts a stream of 4x4 block pairs (source a, reconstruction b) and computes a per-block distortion from weighted 4x4 Hadamard magnitude sums: d = |S(b) − S(a)| >> SHIFT. It accumulates d over a job of 1..N_BLK blocks (N_BLK=16 gives the 16x16 macroblock case) and returns the total through a valid/ready output. It sustains one block pair per cycle with a single shared transform datapath per operand, and adds an unweighted SATD mode.

## Interface
- BIT_WIDTH, 8, pixel width (unsigned)
- N_BLK, 16, max blocks per job (1..16)
- SHIFT, 5, per-block right shift of |S(b)−S(a)|
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  block pair present
- in_ready  out  1  engine can accept
- in_a  in  16*BIT_WIDTH  source pixels; pixel k = row*4+col at [BIT_WIDTH*k +: BIT_WIDTH]
- in_b  in  16*BIT_WIDTH  reconstruction pixels, same packing
- in_w  in  256  unsigned 16-bit weights; w[k] at [16k +: 16]
- in_satd  in  1  1: all weights treated as 1 (in_w ignored)
- in_last  in  1  last block of job
- out_valid  out  1  job result valid; held until accepted
- out_ready  in  1  downstream accepts
- out_sum  out  32  unsigned job total Σd
- out_cnt  out  $clog2(N_BLK+1)  blocks in job

## Operation
- Transform per operand: X[r][c] = pixel r*4+c; C = H·X·Hᵀ, with H rows [1,1,1,1], [1,1,−1,−1], [1,−1,−1,1], [1,−1,1,−1]. S = Σk w[k]·|C[k]|, where k = u*4+v.
- Widths: C is signed, with |C| ≤ 16·(2^BIT_WIDTH−1). Products and S are unsigned. S is 32-bit for BIT_WIDTH=8; wrap-free for all legal inputs.
- d = (S(b)≥S(a) ? S(b)−S(a) : S(a)−S(b)) >> SHIFT, logical shift.
- Job control:
  - A block counter counts accepted beats.
  - A job ends on the beat with in_last=1, or on the N_BLK-th beat even if in_last=0. A forced end restarts counting at the next beat.
  - The accumulator starts from 0 for every job's first block.
- Pipeline:
  - S1: horizontal butterflies for a and b.
  - S2: vertical butterflies plus abs.
  - S3: weight multiply plus 16-term sum giving S(a) and S(b).
  - S4: d, then accumulate. On the job-end block, load out_sum = acc+d and out_cnt, set out_valid, and clear acc.
- Flow control:
  - en = !(out_valid && !out_ready); in_ready = en && !rst.
  - When en=0 all pipeline stages, the counter and the accumulator freeze. Nothing is lost.
- out_valid clears on handshake unless a new result loads in the same cycle, in which case it stays 1 with new data.
- in_w and in_satd are sampled per beat and travel with their block. Mixing modes within a job is legal.
- Reset mid-job discards all in-flight blocks and the partial accumulation.

## Timing
- Reset values: in_ready=0 while rst=1, 1 in the cycle after rst drops. out_valid=0, out_sum=0, out_cnt=0, all stage valids=0, counter=0, acc=0.
- Latency: a job-end beat accepted at edge t gives out_valid=1 after edge t+4 with no stalls. Each stall cycle adds 1.
- Throughput: 1 beat/cycle while out_ready=1. With out_ready held high, back-to-back single-block jobs produce out_valid every cycle.
- A beat is accepted only when in_valid && in_ready. Upstream must hold its data while in_ready=0.
- Output is stable while out_valid && !out_ready.

## Test plan
- a=b random, 16 beats, in_last only on beat 16, weighted -> out_sum=0, out_cnt=16, exactly one out_valid.
- One beat with a=all 0, b=all 10, w=all 1, in_last=1 -> C00=160, out_sum=5, out_cnt=1, out_valid at t+4.
- Same pixels with w=all 0: in_satd=0 -> out_sum=0; in_satd=1 -> out_sum=5.
- Max case: a=0, b=255, w[0]=65535, other w=0, 16 beats -> out_sum=16·8355712=133691392, no overflow.
- Back-pressure:
  - Stimulus: two 3-block jobs sent back-to-back; out_ready=0 for 6 cycles when job 1's result appears.
  - Required: in_ready drops and job 1's result holds steady; after the handshake, job 2's result is correct and no beats are lost or duplicated.
- Reset after 7 beats of a job, then a 3-beat job with in_last -> no output from the aborted job; the next result has out_cnt=3 and the correct sum. An N_BLK overrun (20 beats, no in_last) -> results with cnt=16 and cnt=4 (the latter when in_last arrives on beat 20).

Source files
------------

// File: rtl/tdisto_accum.sv
// tdisto_accum: per-block weighted 4x4 Hadamard distortion |S(b)-S(a)|>>SHIFT, summed over a job.
// Registers: row butterflies, column butterflies+abs, weighted sums, shifted |diff|, accumulate/output.
module tdisto_accum #(
   parameter int BIT_WIDTH = 8,
   parameter int N_BLK     = 16,
   parameter int SHIFT     = 5,
   localparam int CNT_W    = $clog2(N_BLK + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [16*BIT_WIDTH-1:0] in_a,
   input  logic [16*BIT_WIDTH-1:0] in_b,
   input  logic [255:0]            in_w,
   input  logic                    in_satd,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_sum,
   output logic [CNT_W-1:0]        out_cnt
);
   localparam int STAGES = 4;
   localparam int CW     = BIT_WIDTH + 5;   // signed coefficient, |C| <= 16*(2^BW-1)
   localparam int AW     = BIT_WIDTH + 4;
   localparam int SW     = AW + 20;         // 16-bit weight product plus 16-term growth

   typedef logic signed [CW-1:0] coef_t;
   typedef logic [AW-1:0]        mag_t;
   typedef logic [SW-1:0]        sum_t;

   logic             en, accept, job_end;
   logic [CNT_W-1:0] blk_q, blk_d;
   logic [STAGES:1]  vld_pipe_q, last_pipe_q;
   logic [CNT_W-1:0] cnt_pipe_q [STAGES:1];

   coef_t        px    [2][16];
   coef_t        row_d [2][16];
   coef_t        row_q [2][16];
   coef_t        col   [2][16];
   mag_t         mag_d [2][16];
   mag_t         mag_q [2][16];
   logic [255:0] w_eff, w1_q, w2_q;
   sum_t         s_d [2];
   sum_t         s_q [2];
   sum_t         d_d, d_q;
   logic [31:0]  acc_q, tot;
   logic         out_valid_q;
   logic [31:0]  out_sum_q;
   logic [CNT_W-1:0] out_cnt_q;

   assign en       = !(out_valid_q && !out_ready);
   assign in_ready = en && !rst;
   assign accept   = in_valid && in_ready;

   // A job closes on in_last or when the block counter hits N_BLK.
   assign job_end  = in_last || (blk_q == CNT_W'(N_BLK - 1));
   assign blk_d    = job_end ? '0 : blk_q + CNT_W'(1);
   assign w_eff    = in_satd ? {16{16'd1}} : in_w;

   always_comb begin
      for (int k = 0; k < 16; k++) begin
         px[0][k] = coef_t'(in_a[BIT_WIDTH*k +: BIT_WIDTH]);
         px[1][k] = coef_t'(in_b[BIT_WIDTH*k +: BIT_WIDTH]);
      end
      for (int o = 0; o < 2; o++) begin
         for (int r = 0; r < 4; r++) begin
            row_d[o][4*r+0] = px[o][4*r] + px[o][4*r+1] + px[o][4*r+2] + px[o][4*r+3];
            row_d[o][4*r+1] = px[o][4*r] + px[o][4*r+1] - px[o][4*r+2] - px[o][4*r+3];
            row_d[o][4*r+2] = px[o][4*r] - px[o][4*r+1] - px[o][4*r+2] + px[o][4*r+3];
            row_d[o][4*r+3] = px[o][4*r] - px[o][4*r+1] + px[o][4*r+2] - px[o][4*r+3];
         end
      end
   end

   always_comb begin
      for (int o = 0; o < 2; o++) begin
         for (int v = 0; v < 4; v++) begin
            col[o][v]    = row_q[o][v] + row_q[o][4+v] + row_q[o][8+v] + row_q[o][12+v];
            col[o][4+v]  = row_q[o][v] + row_q[o][4+v] - row_q[o][8+v] - row_q[o][12+v];
            col[o][8+v]  = row_q[o][v] - row_q[o][4+v] - row_q[o][8+v] + row_q[o][12+v];
            col[o][12+v] = row_q[o][v] - row_q[o][4+v] + row_q[o][8+v] - row_q[o][12+v];
         end
         for (int k = 0; k < 16; k++)
            mag_d[o][k] = mag_t'(col[o][k][CW-1] ? -col[o][k] : col[o][k]);
      end
   end

   always_comb begin
      for (int o = 0; o < 2; o++) begin
         s_d[o] = '0;
         for (int k = 0; k < 16; k++)
            s_d[o] = s_d[o] + sum_t'(w2_q[16*k +: 16]) * sum_t'(mag_q[o][k]);
      end
      d_d = ((s_q[1] >= s_q[0]) ? s_q[1] - s_q[0] : s_q[0] - s_q[1]) >> SHIFT;
   end

   assign tot = acc_q + 32'(d_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_q       <= '0;
         vld_pipe_q  <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cnt_q   <= '0;
      end else if (en) begin
         if (accept) blk_q <= blk_d;
         vld_pipe_q  <= {vld_pipe_q[STAGES-1:1], accept};
         out_valid_q <= vld_pipe_q[STAGES] && last_pipe_q[STAGES];
         if (vld_pipe_q[STAGES]) begin
            if (last_pipe_q[STAGES]) begin
               out_sum_q <= tot;
               out_cnt_q <= cnt_pipe_q[STAGES];
               acc_q     <= '0;
            end else begin
               acc_q     <= tot;
            end
         end
      end
   end

   // Datapath needs no reset: every consumer is qualified by vld_pipe_q.
   always_ff @(posedge clk) begin
      if (en) begin
         row_q         <= row_d;
         w1_q          <= w_eff;
         w2_q          <= w1_q;
         mag_q         <= mag_d;
         s_q           <= s_d;
         d_q           <= d_d;
         last_pipe_q   <= {last_pipe_q[STAGES-1:1], job_end};
         cnt_pipe_q[1] <= blk_q + CNT_W'(1);
         for (int i = 2; i <= STAGES; i++) cnt_pipe_q[i] <= cnt_pipe_q[i-1];
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_cnt   = out_cnt_q;

endmodule
